acc_snapshot_tx: RTL and testbench

Downstream stage of the integrator core. It snapshots the accumulator output and overflow flag, either on request or after every N accepted input samples. Each snapshot is shifted out MSB-first as a framed serial word (cs_n/sclk/sdo) to an external reader such as an MCU or logic analyser. It also counts snapshots lost because the serializer was busy.

---
 rtl/acc_snapshot_tx.sv | 178 +++++++++++++++++
 tb/tb_acc_snapshot_tx.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_snapshot_tx.sv
// Snapshot of the integrator accumulator and overflow flag, taken on request or every N
// sample strobes, shifted out MSB-first as a framed serial word (cs_n/sclk/sdo).
module acc_snapshot_tx #(
  parameter int ACC_W   = 16,
  parameter int DECIM_W = 8,
  parameter int CLK_DIV = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic signed [ACC_W-1:0] acc_in,
  input  logic                    ovf_in,
  input  logic                    sample_strobe,
  input  logic [DECIM_W-1:0]      decim_ratio,
  input  logic                    snap_req,
  output logic                    ser_cs_n,
  output logic                    ser_sclk,
  output logic                    ser_sdo,
  output logic                    busy,
  output logic [7:0]              drop_count
);

  localparam int BIT_W = $clog2(ACC_W + 1);
  localparam int DIV_W = $clog2(2 * CLK_DIV) + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(ACC_W);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic                 sample_strobe_q;
  logic                 snap_req_q;
  logic [DECIM_W-1:0]   decim_cnt;
  logic                 pending;
  logic [1:0]           state;
  logic [BIT_W-1:0]     bit_idx;
  logic [DIV_W-1:0]     div_cnt;
  logic [ACC_W:0]       shadow;

  logic                 strobe_rise;
  logic                 req_rise;
  logic [DECIM_W:0]     cnt_inc;
  logic                 decim_step;
  logic                 auto_trig;
  logic                 trig;
  logic                 accept;
  logic                 drop;

  logic [1:0]           state_nx;
  logic [BIT_W-1:0]     bit_idx_nx;
  logic [DIV_W-1:0]     div_cnt_nx;
  logic                 load;
  logic [ACC_W:0]       shadow_nx;
  logic                 cs_n_nx;
  logic                 sclk_nx;
  logic                 sdo_nx;

  // ---- trigger detection
  assign strobe_rise = sample_strobe & ~sample_strobe_q;
  assign req_rise    = snap_req & ~snap_req_q;
  assign cnt_inc     = {1'b0, decim_cnt} + (DECIM_W + 1)'(1);
  assign decim_step  = enable & strobe_rise & (decim_ratio != '0);
  assign auto_trig   = decim_step & (cnt_inc >= {1'b0, decim_ratio});
  assign trig        = enable & (auto_trig | req_rise);
  assign accept      = trig & (state == ST_IDLE) & ~pending;
  assign drop        = trig & ~accept;

  assign busy = pending | (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_strobe_q <= 1'b0;
      snap_req_q      <= 1'b0;
      decim_cnt       <= '0;
      drop_count      <= 8'd0;
    end else begin
      sample_strobe_q <= sample_strobe;
      snap_req_q      <= snap_req;
      if (decim_ratio == '0)
        decim_cnt <= '0;
      else if (decim_step)
        decim_cnt <= auto_trig ? '0 : cnt_inc[DECIM_W-1:0];
      if (drop)
        drop_count <= sat_inc8(drop_count);
    end
  end

  // ---- frame sequencer next state
  always_comb begin
    state_nx   = state;
    bit_idx_nx = bit_idx;
    div_cnt_nx = div_cnt;
    load       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pending) begin
          load       = 1'b1;
          state_nx   = ST_SHIFT;
          bit_idx_nx = BIT_TOP;
          div_cnt_nx = '0;
        end
      end
      ST_SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nx = '0;
          if (bit_idx == '0)
            state_nx = ST_GAP;
          else
            bit_idx_nx = bit_idx - BIT_W'(1);
        end else begin
          div_cnt_nx = div_cnt + DIV_W'(1);
        end
      end
      ST_GAP: begin
        if (div_cnt == GAP_LAST) begin
          state_nx   = ST_IDLE;
          div_cnt_nx = '0;
        end else begin
          div_cnt_nx = div_cnt + DIV_W'(1);
        end
      end
      default: begin
        state_nx   = ST_IDLE;
        div_cnt_nx = '0;
      end
    endcase
  end

  // Outputs are derived from the next state and registered, so pins never glitch.
  assign shadow_nx = load ? {ovf_in, acc_in} : shadow;

  always_comb begin
    cs_n_nx = 1'b1;
    sclk_nx = 1'b0;
    sdo_nx  = 1'b0;
    if (state_nx == ST_SHIFT) begin
      cs_n_nx = 1'b0;
      sclk_nx = (div_cnt_nx >= DIV_HALF);
      sdo_nx  = shadow_nx[bit_idx_nx];
    end
  end

  // ---- sequencer and serial output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= 1'b0;
      state    <= ST_IDLE;
      bit_idx  <= '0;
      div_cnt  <= '0;
      ser_cs_n <= 1'b1;
      ser_sclk <= 1'b0;
      ser_sdo  <= 1'b0;
    end else begin
      pending  <= accept | (pending & ~load);
      state    <= state_nx;
      bit_idx  <= bit_idx_nx;
      div_cnt  <= div_cnt_nx;
      ser_cs_n <= cs_n_nx;
      ser_sclk <= sclk_nx;
      ser_sdo  <= sdo_nx;
    end
  end

  // Snapshot data carries no reset; it is only observed after a load.
  always_ff @(posedge clk) begin
    if (load)
      shadow <= {ovf_in, acc_in};
  end

endmodule

// File: tb/tb_acc_snapshot_tx.sv
// Directed bench for acc_snapshot_tx: a negedge monitor decodes frames, and each scenario
// compares them with hand-computed words, lengths and drop counts.
module tb_acc_snapshot_tx;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic signed [15:0] acc_in;
  logic               ovf_in;
  logic               sample_strobe;
  logic [7:0]         decim_ratio;
  logic               snap_req;
  logic               ser_cs_n;
  logic               ser_sclk;
  logic               ser_sdo;
  logic               busy;
  logic [7:0]         drop_count;

  int total = 0;
  int bad   = 0;

  acc_snapshot_tx #(.ACC_W(16), .DECIM_W(8), .CLK_DIV(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .acc_in        (acc_in),
    .ovf_in        (ovf_in),
    .sample_strobe (sample_strobe),
    .decim_ratio   (decim_ratio),
    .snap_req      (snap_req),
    .ser_cs_n      (ser_cs_n),
    .ser_sclk      (ser_sclk),
    .ser_sdo       (ser_sdo),
    .busy          (busy),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame monitor: one entry per completed cs_n-low window
  logic [16:0] fw[$];
  int          fn[$];
  int          fl[$];
  int          glitch_cnt = 0;

  initial begin
    logic        in_frame;
    logic        sclk_prev;
    logic        sdo_prev;
    logic [16:0] cur;
    int          nb;
    int          len;
    in_frame  = 1'b0;
    sclk_prev = 1'b0;
    sdo_prev  = 1'b0;
    cur       = '0;
    nb        = 0;
    len       = 0;
    forever begin
      @(negedge clk);
      if (ser_cs_n === 1'b0) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          cur      = '0;
          nb       = 0;
          len      = 0;
        end
        len++;
        if (ser_sclk && !sclk_prev) begin
          cur = {cur[15:0], ser_sdo};
          nb++;
        end
        if (ser_sclk && sclk_prev && (ser_sdo !== sdo_prev))
          glitch_cnt++;
      end else if (in_frame) begin
        in_frame = 1'b0;
        fw.push_back(cur);
        fn.push_back(nb);
        fl.push_back(len);
      end
      sclk_prev = ser_sclk;
      sdo_prev  = ser_sdo;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe_pulse();
    sample_strobe = 1'b1;
    tick(1);
    sample_strobe = 1'b0;
  endtask

  task automatic snap_pulse();
    snap_req = 1'b1;
    tick(1);
    snap_req = 1'b0;
  endtask

  task automatic clear_frames();
    fw.delete();
    fn.delete();
    fl.delete();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while ((busy || !ser_cs_n) && k < budget) begin
      tick(1);
      k++;
    end
    tick(2);
    chk(tag, 32'(k < budget), 32'd1);
  endtask

  task automatic wait_cs_low(input string tag, input int budget);
    int k;
    k = 0;
    while (ser_cs_n && k < budget) begin
      tick(1);
      k++;
    end
    chk(tag, 32'(k < budget), 32'd1);
  endtask

  task automatic chk_frame(input string tag, input int idx, input logic [16:0] exp_word);
    if (fw.size() > idx) begin
      chk({tag, "_word"}, 32'(fw[idx]), 32'(exp_word));
      chk({tag, "_bits"}, fn[idx], 32'd17);
      chk({tag, "_len"},  fl[idx], 32'd68);
    end else begin
      chk({tag, "_present"}, fw.size(), idx + 1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    int k;
    int low_len;
    rst           = 1'b1;
    enable        = 1'b0;
    acc_in        = '0;
    ovf_in        = 1'b0;
    sample_strobe = 1'b0;
    decim_ratio   = 8'd0;
    snap_req      = 1'b0;
    tick(3);
    chk("rst_cs_n",  32'(ser_cs_n),   32'd1);
    chk("rst_sclk",  32'(ser_sclk),   32'd0);
    chk("rst_sdo",   32'(ser_sdo),    32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_drops", 32'(drop_count), 32'd0);
    rst = 1'b0;
    tick(2);

    // Manual snapshot with cycle-level timing of cs_n and busy
    enable = 1'b1;
    acc_in = 16'h1234;
    ovf_in = 1'b1;
    clear_frames();
    snap_pulse();
    chk("man_busy_pending", 32'(busy), 32'd1);
    wait_cs_low("man_cs_wait", 10);
    low_len = 0;
    while (!ser_cs_n && low_len < 200) begin
      tick(1);
      low_len++;
    end
    chk("man_cs_len", low_len, 32'd68);
    k = 0;
    while (busy && k < 10) begin
      tick(1);
      k++;
    end
    chk("man_busy_tail", k, 32'd2);
    tick(2);
    chk("man_nframes", fw.size(), 32'd1);
    chk_frame("man", 0, 17'h11234);

    // Decimation by 4: the captured value is the one present the cycle after the rise
    clear_frames();
    ovf_in      = 1'b0;
    decim_ratio = 8'd4;
    for (int i = 0; i < 10; i++) begin
      acc_in = 16'h5555;
      strobe_pulse();
      acc_in = 16'hA000 + 16'(i);
      tick(99);
    end
    wait_idle("dec_idle", 200);
    chk("dec_nframes", fw.size(), 32'd2);
    chk_frame("dec0", 0, 17'h0A003);
    chk_frame("dec1", 1, 17'h0A007);
    chk("dec_drops", 32'(drop_count), 32'd0);

    // Overrun: a rise every 20 cycles; only rises 0, 4 and 8 find the block idle
    clear_frames();
    decim_ratio = 8'd1;
    acc_in      = 16'h00FF;
    ovf_in      = 1'b1;
    for (int i = 0; i < 10; i++) begin
      strobe_pulse();
      tick(19);
    end
    wait_idle("ovr_idle", 200);
    chk("ovr_nframes", fw.size(), 32'd3);
    chk_frame("ovr0", 0, 17'h100FF);
    chk("ovr_drops", 32'(drop_count), 32'd7);

    for (int i = 0; i < 300; i++) begin
      strobe_pulse();
      tick(1);
    end
    wait_idle("sat_idle", 200);
    chk("sat_drops", 32'(drop_count), 32'd255);
    do_reset();
    chk("sat_reset_drops", 32'(drop_count), 32'd0);

    // Manual and auto trigger in the same cycle, then a held-high request
    clear_frames();
    decim_ratio = 8'd2;
    acc_in      = 16'h7E01;
    ovf_in      = 1'b0;
    strobe_pulse();
    tick(50);
    sample_strobe = 1'b1;
    snap_req      = 1'b1;
    tick(1);
    sample_strobe = 1'b0;
    tick(99);
    wait_idle("sim_idle", 200);
    chk("sim_nframes", fw.size(), 32'd1);
    chk("sim_drops", 32'(drop_count), 32'd0);
    chk_frame("sim", 0, 17'h07E01);
    strobe_pulse();
    tick(99);
    strobe_pulse();
    tick(99);
    wait_idle("hold_idle", 200);
    chk("hold_nframes", fw.size(), 32'd2);
    chk("hold_drops", 32'(drop_count), 32'd0);
    snap_req = 1'b0;
    tick(2);

    // Reset in the middle of a frame
    clear_frames();
    decim_ratio = 8'd0;
    acc_in      = 16'h5A5A;
    ovf_in      = 1'b1;
    snap_pulse();
    wait_cs_low("mid_cs_wait", 10);
    tick(20);
    snap_pulse();
    chk("mid_drop_before", 32'(drop_count), 32'd1);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_cs_n",  32'(ser_cs_n),   32'd1);
    chk("mid_rst_sclk",  32'(ser_sclk),   32'd0);
    chk("mid_rst_sdo",   32'(ser_sdo),    32'd0);
    chk("mid_rst_busy",  32'(busy),       32'd0);
    chk("mid_rst_drops", 32'(drop_count), 32'd0);
    rst = 1'b0;
    tick(2);
    clear_frames();
    acc_in = 16'h8001;
    ovf_in = 1'b0;
    snap_pulse();
    wait_idle("post_rst_idle", 200);
    chk("post_rst_nframes", fw.size(), 32'd1);
    chk_frame("post_rst", 0, 17'h08001);

    // Enable gating: nothing happens, and the decimation counter does not move
    clear_frames();
    enable      = 1'b0;
    decim_ratio = 8'd3;
    for (int i = 0; i < 8; i++) begin
      strobe_pulse();
      tick(4);
      snap_pulse();
      tick(4);
    end
    chk("gate_busy", 32'(busy), 32'd0);
    chk("gate_nframes", fw.size(), 32'd0);
    chk("gate_drops", 32'(drop_count), 32'd0);
    enable = 1'b1;
    acc_in = 16'h0F0F;
    strobe_pulse();
    tick(99);
    chk("gate_hold_nframes", fw.size(), 32'd0);
    strobe_pulse();
    tick(50);
    strobe_pulse();
    wait_idle("gate_idle", 200);
    chk("gate_resume_nframes", fw.size(), 32'd1);
    chk_frame("gate_resume", 0, 17'h00F0F);

    // Enable dropped mid-frame; acc_in changes during shifting are ignored
    decim_ratio = 8'd0;
    acc_in      = 16'hC3C3;
    ovf_in      = 1'b1;
    snap_pulse();
    wait_cs_low("en_cs_wait", 10);
    tick(10);
    enable = 1'b0;
    acc_in = 16'h0000;
    ovf_in = 1'b0;
    wait_idle("en_idle", 200);
    chk("en_nframes", fw.size(), 32'd2);
    chk_frame("en_mid", 1, 17'h1C3C3);
    snap_pulse();
    tick(100);
    chk("en_off_nframes", fw.size(), 32'd2);
    chk("en_off_drops", 32'(drop_count), 32'd0);

    chk("sdo_stable_high", glitch_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
